// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_pkg
// Description : Shared register map, STATUS bit positions, response codes
//               and the register-index type for the AXI4-Lite CSR slave.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

    localparam int c_NUM_REGS  = 16;
    localparam int c_REG_IDX_W = 4;
    localparam int c_STATUS_W  = 4;

    // Word index into the 16-entry register file
    typedef logic [c_REG_IDX_W-1:0] reg_idx_t;

    // Register offsets, in words (byte offset = index * 4)
    localparam reg_idx_t c_REG_CTRL          = 4'h0;  // 0x00
    localparam reg_idx_t c_REG_STATUS        = 4'h1;  // 0x04
    localparam reg_idx_t c_REG_TOTAL_CYCLES  = 4'h2;  // 0x08
    localparam reg_idx_t c_REG_RD_CYCLES     = 4'h3;  // 0x0C
    localparam reg_idx_t c_REG_PR_CYCLES     = 4'h4;  // 0x10
    localparam reg_idx_t c_REG_WR_CYCLES     = 4'h5;  // 0x14
    localparam reg_idx_t c_REG_SCRATCH_FIRST = 4'h6;  // 0x18 .. 0x3C

    // STATUS bit positions
    localparam int c_STAT_TX_DONE = 0;
    localparam int c_STAT_RD_DONE = 1;
    localparam int c_STAT_PR_DONE = 2;
    localparam int c_STAT_WR_DONE = 3;

    // CTRL bit that requests a transaction
    localparam int c_CTRL_START_BIT = 0;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // True for registers backed by host-writable storage
    function automatic logic is_rw_reg(input reg_idx_t idx);
        return (idx == c_REG_CTRL) || (idx >= c_REG_SCRATCH_FIRST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_regfile
// Description : Byte-strobed R/W storage for CTRL and scratch words, plus the
//               combinational read mux over storage, STATUS and the perf
//               counters. Counters are visible only when
//               AXI4_LITE_PERF_CNTR_EN is defined; otherwise they read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int PERF_CNTR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_we,
    input  reg_idx_t                   i_wr_idx,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
    input  logic [DATA_WIDTH/8-1:0]    i_wstrb,
    input  reg_idx_t                   i_rd_idx,
    input  logic [c_STATUS_W-1:0]      i_status,
    input  logic [PERF_CNTR_WIDTH-1:0] i_total_cycles,
    input  logic [PERF_CNTR_WIDTH-1:0] i_rd_cycles,
    input  logic [PERF_CNTR_WIDTH-1:0] i_pr_cycles,
    input  logic [PERF_CNTR_WIDTH-1:0] i_wr_cycles,
    output logic [DATA_WIDTH-1:0]      o_rdata
);

    logic [DATA_WIDTH-1:0] w_words [c_NUM_REGS];
    logic [DATA_WIDTH-1:0] w_total_cycles;
    logic [DATA_WIDTH-1:0] w_rd_cycles;
    logic [DATA_WIDTH-1:0] w_pr_cycles;
    logic [DATA_WIDTH-1:0] w_wr_cycles;

    for (genvar gi = 0; gi < c_NUM_REGS; gi++) begin : g_reg
        if (is_rw_reg(reg_idx_t'(gi))) begin : g_rw
            logic [DATA_WIDTH-1:0] r_word;

            // Byte-lane write of one storage word
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_word <= '0;
                end else if (i_we && (i_wr_idx == reg_idx_t'(gi))) begin
                    for (int b = 0; b < DATA_WIDTH/8; b++) begin
                        if (i_wstrb[b]) begin
                            r_word[b*8 +: 8] <= i_wdata[b*8 +: 8];
                        end
                    end
                end
            end

            assign w_words[gi] = r_word;
        end else begin : g_ro
            // Read-only slots have no storage; writes here are dropped
            assign w_words[gi] = '0;
        end
    end

`ifdef AXI4_LITE_PERF_CNTR_EN
    // Size cast zero-extends narrower counters and truncates wider ones
    assign w_total_cycles = DATA_WIDTH'(i_total_cycles);
    assign w_rd_cycles    = DATA_WIDTH'(i_rd_cycles);
    assign w_pr_cycles    = DATA_WIDTH'(i_pr_cycles);
    assign w_wr_cycles    = DATA_WIDTH'(i_wr_cycles);
`else
    logic w_unused_cntrs;
    assign w_unused_cntrs = ^{i_total_cycles, i_rd_cycles, i_pr_cycles, i_wr_cycles};
    assign w_total_cycles = '0;
    assign w_rd_cycles    = '0;
    assign w_pr_cycles    = '0;
    assign w_wr_cycles    = '0;
`endif

    // Read mux: storage by default, live sources for the read-only slots
    always_comb begin
        o_rdata = w_words[i_rd_idx];
        case (i_rd_idx)
            c_REG_STATUS:       o_rdata = DATA_WIDTH'(i_status);
            c_REG_TOTAL_CYCLES: o_rdata = w_total_cycles;
            c_REG_RD_CYCLES:    o_rdata = w_rd_cycles;
            c_REG_PR_CYCLES:    o_rdata = w_pr_cycles;
            c_REG_WR_CYCLES:    o_rdata = w_wr_cycles;
            default:            ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_slave
// Description : AXI4-Lite control/status slave for the accelerator host
//               interface. Write and read channel FSMs, the tx_req start
//               pulse and the sticky STATUS latches live here; storage and
//               the read mux are in axi4_lite_regfile.
//               Optional macro AXI4_LITE_PERF_CNTR_EN exposes the perf
//               counters at 0x08-0x14 (read as 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXIS_ADDR_WIDTH = 6,
    parameter int PERF_CNTR_WIDTH = 32
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESET,
    input  logic [AXIS_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                   S_AXI_AWPROT,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [AXIS_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXIS_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [AXIS_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                   S_AXI_ARPROT,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [AXIS_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic                         tx_req,
    input  logic                         tx_done,
    input  logic                         rd_done,
    input  logic                         processing_done,
    input  logic                         wr_done,
    input  logic [PERF_CNTR_WIDTH-1:0]   total_cycles,
    input  logic [PERF_CNTR_WIDTH-1:0]   rd_cycles,
    input  logic [PERF_CNTR_WIDTH-1:0]   pr_cycles,
    input  logic [PERF_CNTR_WIDTH-1:0]   wr_cycles
);

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_ACCEPT = 2'd1,
        W_RESP   = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_ACCEPT = 2'd1,
        R_RESP   = 2'd2
    } rd_state_t;

    wr_state_t r_wr_state;
    rd_state_t r_rd_state;

    logic                       r_awready;
    logic                       r_wready;
    logic                       r_bvalid;
    logic                       r_arready;
    logic                       r_rvalid;
    logic [AXIS_DATA_WIDTH-1:0] r_rdata;
    logic                       r_tx_req;
    logic [c_STATUS_W-1:0]      r_status;

    logic                       w_wr_hs;
    logic                       w_rd_hs;
    logic                       w_ctrl_start;
    reg_idx_t                   w_wr_idx;
    reg_idx_t                   w_rd_idx;
    logic [c_STATUS_W-1:0]      w_status_set;
    logic [AXIS_DATA_WIDTH-1:0] w_rd_data;
    logic                       w_unused_top;

    // Upper address bits beyond the 16-word map alias onto it
    assign w_wr_idx = reg_idx_t'(S_AXI_AWADDR[AXIS_ADDR_WIDTH-1:2]);
    assign w_rd_idx = reg_idx_t'(S_AXI_ARADDR[AXIS_ADDR_WIDTH-1:2]);

    // Both write channels complete on the same edge; neither is taken alone
    assign w_wr_hs = r_awready & S_AXI_AWVALID & r_wready & S_AXI_WVALID;
    assign w_rd_hs = r_arready & S_AXI_ARVALID;

    assign w_ctrl_start = w_wr_hs && (w_wr_idx == c_REG_CTRL)
                          && S_AXI_WSTRB[0] && S_AXI_WDATA[c_CTRL_START_BIT];

    assign w_status_set[c_STAT_TX_DONE] = tx_done;
    assign w_status_set[c_STAT_RD_DONE] = rd_done;
    assign w_status_set[c_STAT_PR_DONE] = processing_done;
    assign w_status_set[c_STAT_WR_DONE] = wr_done;

    assign w_unused_top = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                            S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write channel: ready pulse, then B response held until BREADY
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid) begin
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                        r_wr_state <= W_ACCEPT;
                    end
                end
                W_ACCEPT: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    if (w_wr_hs) begin
                        r_bvalid   <= 1'b1;
                        r_wr_state <= W_RESP;
                    end else begin
                        r_wr_state <= W_IDLE;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid   <= 1'b0;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: begin
                    r_awready  <= 1'b0;
                    r_wready   <= 1'b0;
                    r_bvalid   <= 1'b0;
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel: ready pulse, then RDATA/RVALID held until RREADY
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID && !r_rvalid) begin
                        r_arready  <= 1'b1;
                        r_rd_state <= R_ACCEPT;
                    end
                end
                R_ACCEPT: begin
                    r_arready <= 1'b0;
                    if (w_rd_hs) begin
                        r_rdata    <= w_rd_data;
                        r_rvalid   <= 1'b1;
                        r_rd_state <= R_RESP;
                    end else begin
                        r_rd_state <= R_IDLE;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        r_rvalid   <= 1'b0;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: begin
                    r_arready  <= 1'b0;
                    r_rvalid   <= 1'b0;
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

    // Start pulse and sticky status; a same-edge done input beats the clear
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_tx_req <= 1'b0;
            r_status <= '0;
        end else begin
            r_tx_req <= w_ctrl_start;
            r_status <= w_status_set | (r_status & ~{c_STATUS_W{w_ctrl_start}});
        end
    end

    axi4_lite_regfile #(
        .DATA_WIDTH      (AXIS_DATA_WIDTH),
        .PERF_CNTR_WIDTH (PERF_CNTR_WIDTH)
    ) u_regfile (
        .clk            (S_AXI_ACLK),
        .rst            (S_AXI_ARESET),
        .i_we           (w_wr_hs),
        .i_wr_idx       (w_wr_idx),
        .i_wdata        (S_AXI_WDATA),
        .i_wstrb        (S_AXI_WSTRB),
        .i_rd_idx       (w_rd_idx),
        .i_status       (r_status),
        .i_total_cycles (total_cycles),
        .i_rd_cycles    (rd_cycles),
        .i_pr_cycles    (pr_cycles),
        .i_wr_cycles    (wr_cycles),
        .o_rdata        (w_rd_data)
    );

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign tx_req        = r_tx_req;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_lite_slave
// Description : Scoreboard bench for axi4_lite_slave. Stimulus pushes the
//               expected B/R responses; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_slave;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int CW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rexp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic          tx_req;
    logic          tx_done, rd_done, processing_done, wr_done;
    logic [CW-1:0] total_cycles, rd_cycles, pr_cycles, wr_cycles;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    tx_req_cycles = 0;
    rexp_t rq[$];
    logic [1:0] bq[$];

    always #5 clk = ~clk;

    axi4_lite_slave #(
        .AXIS_DATA_WIDTH (DW),
        .AXIS_ADDR_WIDTH (AW),
        .PERF_CNTR_WIDTH (CW)
    ) dut (
        .S_AXI_ACLK      (clk),
        .S_AXI_ARESET    (rst),
        .S_AXI_AWADDR    (awaddr),
        .S_AXI_AWPROT    (awprot),
        .S_AXI_AWVALID   (awvalid),
        .S_AXI_AWREADY   (awready),
        .S_AXI_WDATA     (wdata),
        .S_AXI_WSTRB     (wstrb),
        .S_AXI_WVALID    (wvalid),
        .S_AXI_WREADY    (wready),
        .S_AXI_BRESP     (bresp),
        .S_AXI_BVALID    (bvalid),
        .S_AXI_BREADY    (bready),
        .S_AXI_ARADDR    (araddr),
        .S_AXI_ARPROT    (arprot),
        .S_AXI_ARVALID   (arvalid),
        .S_AXI_ARREADY   (arready),
        .S_AXI_RDATA     (rdata),
        .S_AXI_RRESP     (rresp),
        .S_AXI_RVALID    (rvalid),
        .S_AXI_RREADY    (rready),
        .tx_req          (tx_req),
        .tx_done         (tx_done),
        .rd_done         (rd_done),
        .processing_done (processing_done),
        .wr_done         (wr_done),
        .total_cycles    (total_cycles),
        .rd_cycles       (rd_cycles),
        .pr_cycles       (pr_cycles),
        .wr_cycles       (wr_cycles)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitor: pops expected responses as the DUT presents them
    always @(negedge clk) begin : p_monitor
        rexp_t      re;
        logic [1:0] be;
        if (!rst) begin
            if (tx_req) tx_req_cycles++;
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    fail("b_unexpected");
                end else begin
                    be = bq.pop_front();
                    check("bresp", 32'(bresp), 32'(be));
                end
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    fail("r_unexpected");
                end else begin
                    re = rq.pop_front();
                    check($sformatf("rdata@%h", re.addr), rdata, re.data);
                    check($sformatf("rresp@%h", re.addr), 32'(rresp), 32'd0);
                end
            end
        end
    end

    task automatic start_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        bq.push_back(2'b00);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
    endtask

    task automatic wait_aw();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        if (!ok) fail("aw_accept");
        else check("wready_with_awready", 32'(wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic wait_b_done();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bvalid && bready) begin ok = 1; break; end
        end
        if (!ok) fail("b_done");
        @(posedge clk); #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        start_write(a, d, s);
        wait_aw();
        wait_b_done();
    endtask

    task automatic start_read(input logic [AW-1:0] a);
        araddr  = a;
        arvalid = 1'b1;
    endtask

    task automatic wait_ar();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        if (!ok) fail("ar_accept");
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bit ok = 0;
        rq.push_back('{addr: a, data: exp});
        start_read(a);
        wait_ar();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rvalid && rready) begin ok = 1; break; end
        end
        if (!ok) fail("r_done");
        @(posedge clk); #1;
    endtask

    initial begin : p_stim
        int            c0;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_cntr;
        logic [DW-1:0] exp_rdc;

        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        tx_done = 1'b0; rd_done = 1'b0; processing_done = 1'b0; wr_done = 1'b0;
        total_cycles = '0; rd_cycles = '0; pr_cycles = '0; wr_cycles = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_tx_req",  32'(tx_req),  32'd0);
        check("rst_resp",    32'({bresp, rresp}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        axi_read(6'h00, 32'h0);
        axi_read(6'h04, 32'h0);
        axi_read(6'h3C, 32'h0);

        // CTRL write/readback with random data
        for (int i = 0; i < 200; i++) begin
            d = $urandom;
            axi_write(6'h00, d, 4'hF);
            axi_read(6'h00, d);
        end

        // Byte strobes on scratch, last scratch word, ignored low address bits
        axi_write(6'h18, 32'hFFFF_FFFF, 4'hF);
        axi_write(6'h18, 32'h0000_0000, 4'b0101);
        axi_read(6'h18, 32'hFF00_FF00);
        axi_write(6'h3F, 32'hA5A5_5A5A, 4'hF);
        axi_read(6'h3C, 32'hA5A5_5A5A);
        axi_read(6'h1A, 32'hFF00_FF00);

        // tx_req pulse width and its qualifiers
        c0 = tx_req_cycles;
        axi_write(6'h00, 32'h1, 4'hF);
        repeat (3) @(posedge clk); #1;
        check("tx_req_width", 32'(tx_req_cycles - c0), 32'd1);
        c0 = tx_req_cycles;
        axi_write(6'h00, 32'h2, 4'hF);
        axi_write(6'h00, 32'h1, 4'b1110);
        repeat (3) @(posedge clk); #1;
        check("tx_req_none", 32'(tx_req_cycles - c0), 32'd0);
        axi_read(6'h00, 32'h2);

        // Sticky STATUS, clear on start, set wins over clear, RO write ignored
        axi_write(6'h00, 32'h1, 4'hF);
        tx_done = 1'b1; wr_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0; wr_done = 1'b0;
        repeat (2) @(posedge clk); #1;
        axi_read(6'h04, 32'h9);
        axi_write(6'h00, 32'h1, 4'hF);
        axi_read(6'h04, 32'h0);
        rd_done = 1'b1;
        axi_write(6'h00, 32'h1, 4'hF);
        rd_done = 1'b0;
        axi_read(6'h04, 32'h2);
        axi_write(6'h00, 32'h1, 4'hF);
        axi_write(6'h04, 32'hFFFF_FFFF, 4'hF);
        axi_read(6'h04, 32'h0);

        // Performance counters
        total_cycles = 32'd1234;
        rd_cycles    = 32'h0BAD_F00D;
`ifdef AXI4_LITE_PERF_CNTR_EN
        exp_cntr = 32'd1234;
        exp_rdc  = 32'h0BAD_F00D;
`else
        exp_cntr = 32'd0;
        exp_rdc  = 32'd0;
`endif
        axi_write(6'h08, 32'h0000_DEAD, 4'hF);
        axi_read(6'h08, exp_cntr);
        axi_read(6'h0C, exp_rdc);

        // B backpressure: second write waits, reads proceed meanwhile
        bready = 1'b0;
        start_write(6'h1C, 32'h1111_1111, 4'hF);
        wait_aw();
        start_write(6'h1C, 32'h2222_2222, 4'hF);
        axi_read(6'h1C, 32'h1111_1111);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("aw_blocked", 32'(awready), 32'd0);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        wait_aw();
        wait_b_done();
        axi_read(6'h1C, 32'h2222_2222);

        // Reset while RVALID is held
        rready = 1'b0;
        start_read(6'h18);
        wait_ar();
        begin
            bit seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rvalid) begin seen = 1; break; end
            end
            if (!seen) fail("rvalid_before_reset");
        end
        check("rdata_before_reset", rdata, 32'hFF00_FF00);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        rq.delete();
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        rready = 1'b1;
        @(posedge clk); #1;
        axi_read(6'h00, 32'h0);
        axi_read(6'h18, 32'h0);

        repeat (3) @(posedge clk); #1;
        check("rq_drained", 32'(rq.size()), 32'd0);
        check("bq_drained", 32'(bq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : p_watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
